shift_sequencer: RTL and testbench

Multi-cycle shift controller for the 16-bit datapath. Accepts a shift request (operation, amount 0–15, operand) through a start/busy/done handshake. Performs the request by applying the existing one-position `shifter` once per clock, iterating `amount` times. Returns the final value in a held result register. It sits between the instruction controller FSM and the shifter, so the datapath gets multi-bit shifts without a barrel shifter.

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_shifter.sv | 24 ++
 rtl/shift_sequencer.sv | 79 +++++++
 tb/tb_shift_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer slice.
// FSM state codes and shifter op codes.
package shift_sequencer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// One-position shifter: a, op -> y.
// op: pass, lsl, lsr, asr (all by one bit).
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      SH_PASS: y = a;
      SH_LSL:  y = {a[W-2:0], 1'b0};
      SH_LSR:  y = {1'b0, a[W-1:1]};
      SH_ASR:  y = {a[W-1], a[W-1:1]};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: start/busy/done handshake,
// iterates a 1-bit shifter amount times; dout holds result.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [CW-1:0] amount,
  input  logic [W-1:0]  din,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  dout
);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [W-1:0]  res;
  logic          zero;
  logic          last;

  shift_sequencer_shifter #(.W(W)) u_shifter (
    .a  (work),
    .op (op_q),
    .y  (work_nx)
  );

  // Nothing to iterate: finish straight from IDLE.
  assign zero = (amount == '0) || (op == SH_PASS);
  assign last = (cnt == CW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = zero ? S_DONE : S_SHIFT;
      S_SHIFT: if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work <= '0;
      cnt  <= '0;
      op_q <= '0;
      res  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        work <= din;
        op_q <= op;
        cnt  <= amount;
        if (zero) res <= din;
      end else if (state == S_SHIFT) begin
        work <= work_nx;
        cnt  <= cnt - CW'(1);
        if (last) res <= work_nx;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign dout = res;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer.
// Reference computes results with whole-word shifts.
module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int total;
  int bad;
  logic [15:0] last_res;

  shift_sequencer #(.W(16), .CW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amount  (amount),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o,
                                        input int n,
                                        input logic [15:0] d);
    logic signed [15:0] s;
    case (o)
      2'b00:   model = d;
      2'b01:   model = 16'(d << n);
      2'b10:   model = d >> n;
      default: begin
        s = d;
        s = s >>> n;
        model = s;
      end
    endcase
  endfunction

  task automatic run_req(input logic [1:0] o,
                         input logic [3:0] n,
                         input logic [15:0] d,
                         input bit poke);
    logic [15:0] exp;
    int lat;
    int k;
    exp = model(o, int'(n), d);
    lat = (n == 0 || o == 2'b00) ? 0 : int'(n);
    @(negedge clk);
    start = 1'b1;
    op = o;
    amount = n;
    din = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    amount = 4'($urandom);
    din = 16'($urandom);
    k = 0;
    chk("busy_t0", busy, 1'b1);
    while (!done && k < 40) begin
      chk("dout_hold", dout, last_res);
      chk("busy_mid", busy, 1'b1);
      if (poke && k == 1) begin
        start = 1'b1;
        din = ~d;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    chk("latency", k, lat);
    chk("result", dout, exp);
    chk("busy_done", busy, 1'b1);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("dout_keep", dout, exp);
    last_res = exp;
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_res = '0;
    reset_n = 1'b0;
    start = 1'b0;
    op = '0;
    amount = '0;
    din = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    run_req(2'b01, 4'd3, 16'h0001, 1'b0);
    chk("lsl3", dout, 16'h0008);
    run_req(2'b11, 4'd4, 16'hF0CF, 1'b0);
    chk("asr4", dout, 16'hFF0C);
    run_req(2'b11, 4'd15, 16'h6000, 1'b0);
    chk("asr15", dout, 16'h0000);
    run_req(2'b11, 4'd15, 16'h8001, 1'b0);
    chk("asr15_neg", dout, 16'hFFFF);
    run_req(2'b10, 4'd15, 16'h8000, 1'b0);
    chk("lsr15", dout, 16'h0001);
    run_req(2'b01, 4'd0, 16'h1234, 1'b0);
    chk("zero_amt", dout, 16'h1234);
    run_req(2'b00, 4'd7, 16'hBEEF, 1'b0);
    chk("zero_pass", dout, 16'hBEEF);
    run_req(2'b01, 4'd6, 16'h00A5, 1'b1);
    chk("poke", dout, 16'h2940);

    // abort a request mid-shift
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    amount = 4'd10;
    din = 16'h0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_dout", dout, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    last_res = '0;
    run_req(2'b10, 4'd2, 16'h00F0, 1'b0);
    chk("after_rst", dout, 16'h003C);

    for (int i = 0; i < 40; i++) begin
      run_req(2'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
